hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Producer-side companion to the forwarding logic in the 5-stage pipeline. Tracks every in-flight register write (destination, write enable, load flag) through the E, M and W stages and supplies the registered `RegDstAddr_M/W` and `RegWriteEN_M/W` that operand forwarding consumes. Uses the same tracking state to detect the hazards forwarding cannot cover: load-use, memory wait and taken branch. For each it drives stall, bubble and flush controls to the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports (clock and reset first):
- `CLK`, in, 1: pipeline clock; all state updates on the rising edge.
- `RST_N`, in, 1: reset, asynchronous and active-low.
- `RsAddr_D`, in, 5: Rs of the instruction in ID.
- `RtAddr_D`, in, 5: Rt of the instruction in ID.
- `UsesRs_D`, in, 1: the ID instruction reads Rs.
- `UsesRt_D`, in, 1: the ID instruction reads Rt.
- `RegDstAddr_D`, in, 5: destination register of the ID instruction.
- `RegWriteEN_D`, in, 1: the ID instruction writes a register.
- `MemRead_D`, in, 1: the ID instruction is a load.
- `BranchTaken_E`, in, 1: a branch in EX resolved as taken.
- `MemWait_M`, in, 1: data memory not ready for the access in M.
- `Stall_F`, out, 1: hold PC.
- `Stall_D`, out, 1: hold IF/ID.
- `Flush_D`, out, 1: clear IF/ID.
- `Bubble_E`, out, 1: load a NOP into ID/EX.
- `Freeze_M`, out, 1: hold EX/MEM and MEM/WB.
- `RegDstAddr_E`, `RegDstAddr_M`, `RegDstAddr_W`, out, 5 each: tracked destinations.
- `RegWriteEN_E`, `RegWriteEN_M`, `RegWriteEN_W`, out, 1 each: tracked write enables.
- `MemRead_E`, `MemRead_M`, out, 1 each: tracked load flags.
- `StallCount`, out, `CNT_W`: saturating count of cycles with `Stall_D`=1.

## Operation
Per-stage state is {en, addr, load}.
- **Normalisation:** an entry captured with addr=0 stores en=0 and load=0. $0 is never tracked as a producer.

Hazard terms:
- `luE` = `MemRead_E` & `RegWriteEN_E` & ((`UsesRs_D` & `RsAddr_D`==`RegDstAddr_E`) | (`UsesRt_D` & `RtAddr_D`==`RegDstAddr_E`)).
- `luM` = the same comparison against the M entry. It is used only when `LOAD_USE_M_STALL_EN` is defined.

Priority, highest first:
1. **`MemWait_M`=1:**
   - `Freeze_M`=`Stall_F`=`Stall_D`=1; `Bubble_E`=0, `Flush_D`=0.
   - E, M and W all hold.
2. **`BranchTaken_E`=1:**
   - `Flush_D`=1, `Bubble_E`=1, `Stall_F`=`Stall_D`=0.
   - W<=M, M<=E, E<=empty.
3. **`luE` (or `luM` when enabled):**
   - `Stall_F`=`Stall_D`=`Bubble_E`=1.
   - W<=M, M<=E, E<=empty.
4. **Otherwise:** W<=M, M<=E, E<=normalised {`RegWriteEN_D`, `RegDstAddr_D`, `MemRead_D`}.

Other rules:
- "empty" means {0, 0, 0}.
- `StallCount` increments when `Stall_D`=1 and holds at all-ones (saturates, never wraps).

## Timing
- Hazard outputs (`Stall_F`, `Stall_D`, `Flush_D`, `Bubble_E`, `Freeze_M`) are combinational from current state and ID/M inputs, with zero-cycle latency.
- Tracking outputs and `StallCount` are registered; an instruction's destination appears on `_E` one edge after it leaves ID.
- A basic load-use costs exactly 1 stall cycle. The stalled ID instruction re-evaluates the next cycle against the load, which is then in M.
- A simultaneous taken branch and load-use resolves as a flush only; the stalled instruction is discarded.
- `MemWait_M` held for N cycles freezes state for N cycles. Hazard terms are recomputed from the held state when it drops.
- Reset (asserted at any time, including mid-stall or mid-wait):
  - all E, M and W entries clear to empty;
  - `StallCount`=0;
  - the hazard outputs then evaluate from the cleared state: `Stall_F`=`Stall_D`=`Bubble_E`=0, `Flush_D`=`BranchTaken_E`, `Freeze_M`=`MemWait_M`;
  - the first edge after release captures the ID instruction normally.

## Configuration
- **`LOAD_USE_M_STALL_EN` defined:** `luM` also stalls. This is for builds whose load data is forwarded only from W; the load-use penalty becomes 2 cycles.
- **Not defined:** only `luE` stalls; the penalty is 1 cycle and `luM` logic is absent.

## Test plan
- Load $8 enters E; ID reads Rs=$8 with `UsesRs_D`=1 -> one cycle of `Stall_F`=`Stall_D`=`Bubble_E`=1, `RegWriteEN_E`=0 next, `StallCount`=1.
- Load to $0 in E; ID reads $0 -> no stall, `RegWriteEN_E`=0.
- Load $5 in E, ID reads Rt=$5 with `UsesRt_D`=0 -> no stall.
- `BranchTaken_E` and `luE` in the same cycle -> `Flush_D`=1, `Bubble_E`=1, `Stall_D`=0, E empty next.
- `MemWait_M`=1 for 3 cycles with add $3 in M -> `RegDstAddr_M`=3 held for 3 edges, `Freeze_M`=1, `StallCount`=3.
- `RST_N` low mid-wait -> all tracking outputs 0 immediately; `StallCount`=0; `Freeze_M` follows `MemWait_M`; with `LOAD_USE_M_STALL_EN`, a load in M matching Rs stalls for 2 cycles in total.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: tracks in-flight register writes through E/M/W
// and drives stall, bubble, flush and freeze controls. Optional macro: LOAD_USE_M_STALL_EN.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       RsAddr_D,
    input  logic [4:0]       RtAddr_D,
    input  logic             UsesRs_D,
    input  logic             UsesRt_D,
    input  logic [4:0]       RegDstAddr_D,
    input  logic             RegWriteEN_D,
    input  logic             MemRead_D,
    input  logic             BranchTaken_E,
    input  logic             MemWait_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Bubble_E,
    output logic             Freeze_M,
    output logic [4:0]       RegDstAddr_E,
    output logic [4:0]       RegDstAddr_M,
    output logic [4:0]       RegDstAddr_W,
    output logic             RegWriteEN_E,
    output logic             RegWriteEN_M,
    output logic             RegWriteEN_W,
    output logic             MemRead_E,
    output logic             MemRead_M,
    output logic [CNT_W-1:0] StallCount
);

    typedef struct packed {
        logic       en;
        logic [4:0] addr;
        logic       load;
    } entry_t;

    typedef enum logic [1:0] {
        ADV_HOLD,
        ADV_INSERT_EMPTY,
        ADV_CAPTURE
    } advance_t;

    localparam entry_t EMPTY_ENTRY = '0;

    entry_t   entE, entM, entW;
    entry_t   capD;
    logic     luE;
    logic     loadUseHit;
    advance_t advance;

    // True when the ID instruction reads the register a tracked load will write.
    function automatic logic readsLoad(input entry_t p,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic useRs, input logic useRt);
        return p.load & p.en & ((useRs & (rs == p.addr)) | (useRt & (rt == p.addr)));
    endfunction

    // $0 is never a producer, so it is stored as an empty slot.
    always_comb begin
        if (RegDstAddr_D == 5'd0) begin
            capD = EMPTY_ENTRY;
        end else begin
            capD = '{en: RegWriteEN_D, addr: RegDstAddr_D, load: MemRead_D};
        end
    end

    assign luE = readsLoad(entE, RsAddr_D, RtAddr_D, UsesRs_D, UsesRt_D);

`ifdef LOAD_USE_M_STALL_EN
    assign loadUseHit = luE | readsLoad(entM, RsAddr_D, RtAddr_D, UsesRs_D, UsesRt_D);
`else
    assign loadUseHit = luE;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        Stall_F  = 1'b0;
        Stall_D  = 1'b0;
        Flush_D  = 1'b0;
        Bubble_E = 1'b0;
        Freeze_M = 1'b0;
        advance  = ADV_CAPTURE;
        if (!RST_N) begin
            // Held in reset: only the pass-through controls remain visible.
            Flush_D  = BranchTaken_E;
            Freeze_M = MemWait_M;
        end else if (MemWait_M) begin
            Freeze_M = 1'b1;
            Stall_F  = 1'b1;
            Stall_D  = 1'b1;
            advance  = ADV_HOLD;
        end else if (BranchTaken_E) begin
            Flush_D  = 1'b1;
            Bubble_E = 1'b1;
            advance  = ADV_INSERT_EMPTY;
        end else if (loadUseHit) begin
            Stall_F  = 1'b1;
            Stall_D  = 1'b1;
            Bubble_E = 1'b1;
            advance  = ADV_INSERT_EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
            entE <= EMPTY_ENTRY;
            entM <= EMPTY_ENTRY;
            entW <= EMPTY_ENTRY;
        end else begin
            case (advance)
                ADV_HOLD: begin
                    entE <= entE;
                    entM <= entM;
                    entW <= entW;
                end
                ADV_INSERT_EMPTY: begin
                    entW <= entM;
                    entM <= entE;
                    entE <= EMPTY_ENTRY;
                end
                default: begin
                    entW <= entM;
                    entM <= entE;
                    entE <= capD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            StallCount <= '0;
        end else if (Stall_D && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

    assign RegDstAddr_E = entE.addr;
    assign RegDstAddr_M = entM.addr;
    assign RegDstAddr_W = entW.addr;
    assign RegWriteEN_E = entE.en;
    assign RegWriteEN_M = entM.en;
    assign RegWriteEN_W = entW.en;
    assign MemRead_E    = entE.load;
    assign MemRead_M    = entM.load;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a pipeline-list model checked every cycle,
// plus hand-computed literal expectations.
module tb_hazard_scoreboard;

    localparam int CW     = 3;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          CLK, RST_N;
    logic [4:0]    RsAddr_D, RtAddr_D, RegDstAddr_D;
    logic          UsesRs_D, UsesRt_D, RegWriteEN_D, MemRead_D;
    logic          BranchTaken_E, MemWait_M;
    logic          Stall_F, Stall_D, Flush_D, Bubble_E, Freeze_M;
    logic [4:0]    RegDstAddr_E, RegDstAddr_M, RegDstAddr_W;
    logic          RegWriteEN_E, RegWriteEN_M, RegWriteEN_W;
    logic          MemRead_E, MemRead_M;
    logic [CW-1:0] StallCount;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 0;

    hazard_scoreboard #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
        .UsesRs_D(UsesRs_D), .UsesRt_D(UsesRt_D),
        .RegDstAddr_D(RegDstAddr_D), .RegWriteEN_D(RegWriteEN_D), .MemRead_D(MemRead_D),
        .BranchTaken_E(BranchTaken_E), .MemWait_M(MemWait_M),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
        .Bubble_E(Bubble_E), .Freeze_M(Freeze_M),
        .RegDstAddr_E(RegDstAddr_E), .RegDstAddr_M(RegDstAddr_M), .RegDstAddr_W(RegDstAddr_W),
        .RegWriteEN_E(RegWriteEN_E), .RegWriteEN_M(RegWriteEN_M), .RegWriteEN_W(RegWriteEN_W),
        .MemRead_E(MemRead_E), .MemRead_M(MemRead_M),
        .StallCount(StallCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a three-slot list of in-flight writers, index 0 = E, 1 = M, 2 = W.
    typedef struct packed {
        bit       en;
        bit [4:0] addr;
        bit       load;
    } slot_t;

    slot_t pipe [3];
    int    mCount;

    function automatic bit hitsLoad(input slot_t s);
        return s.en && s.load && s.addr != 0 &&
               ((UsesRs_D && RsAddr_D == s.addr) || (UsesRt_D && RtAddr_D == s.addr));
    endfunction

    task automatic expHazards(output bit sF, output bit sD, output bit fD,
                              output bit bE, output bit fM);
        bit lu;
        lu = hitsLoad(pipe[0]);
`ifdef LOAD_USE_M_STALL_EN
        lu = lu || hitsLoad(pipe[1]);
`endif
        {sF, sD, fD, bE, fM} = '0;
        if (!RST_N) begin
            fD = BranchTaken_E;
            fM = MemWait_M;
        end else if (MemWait_M) begin
            {sF, sD, fM} = 3'b111;
        end else if (BranchTaken_E) begin
            {fD, bE} = 2'b11;
        end else if (lu) begin
            {sF, sD, bE} = 3'b111;
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        bit sF, sD, fD, bE, fM;
        slot_t incoming;
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            mCount = 0;
        end else begin
            expHazards(sF, sD, fD, bE, fM);
            if (sD && mCount < CNTMAX) mCount++;
            if (!MemWait_M) begin
                if (bE || RegDstAddr_D == 0) incoming = '0;
                else incoming = '{en: RegWriteEN_D, addr: RegDstAddr_D, load: MemRead_D};
                for (int i = 2; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = incoming;
            end
        end
    end

    always @(negedge CLK) begin
        bit sF, sD, fD, bE, fM;
        if (cmpEn) begin
            expHazards(sF, sD, fD, bE, fM);
            check("Stall_F", Stall_F, sF);
            check("Stall_D", Stall_D, sD);
            check("Flush_D", Flush_D, fD);
            check("Bubble_E", Bubble_E, bE);
            check("Freeze_M", Freeze_M, fM);
            check("RegDstAddr_E", RegDstAddr_E, pipe[0].addr);
            check("RegDstAddr_M", RegDstAddr_M, pipe[1].addr);
            check("RegDstAddr_W", RegDstAddr_W, pipe[2].addr);
            check("RegWriteEN_E", RegWriteEN_E, pipe[0].en);
            check("RegWriteEN_M", RegWriteEN_M, pipe[1].en);
            check("RegWriteEN_W", RegWriteEN_W, pipe[2].en);
            check("MemRead_E", MemRead_E, pipe[0].load);
            check("MemRead_M", MemRead_M, pipe[1].load);
            check("StallCount", StallCount, mCount);
        end
    end

    task automatic setId(input logic [4:0] rs, input logic ur, input logic [4:0] rt, input logic ut,
                         input logic [4:0] dst, input logic we, input logic mr);
        RsAddr_D = rs; UsesRs_D = ur; RtAddr_D = rt; UsesRt_D = ut;
        RegDstAddr_D = dst; RegWriteEN_D = we; MemRead_D = mr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

`ifdef LOAD_USE_M_STALL_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    initial begin
        RST_N = 1'b0;
        BranchTaken_E = 1'b0;
        MemWait_M = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset RegWriteEN_E", RegWriteEN_E, 0);
        check("reset RegDstAddr_M", RegDstAddr_M, 0);
        check("reset StallCount", StallCount, 0);
        check("reset Stall_D", Stall_D, 0);
        step();
        RST_N = 1'b1;
        cmpEn = 1'b1;

        // Load $8 followed by a reader of $8 through Rs.
        setId(0, 0, 0, 0, 8, 1, 1);
        step();
        setId(8, 1, 0, 0, 9, 1, 0);
        #1;
        check("lu Stall_F", Stall_F, 1);
        check("lu Stall_D", Stall_D, 1);
        check("lu Bubble_E", Bubble_E, 1);
        check("lu RegDstAddr_E", RegDstAddr_E, 8);
        step();
        check("lu bubble RegWriteEN_E", RegWriteEN_E, 0);
        check("lu RegDstAddr_M", RegDstAddr_M, 8);
        check("lu StallCount", StallCount, 1);
        check("lu re-eval Stall_D", Stall_D, EXTRA);
        step();
        if (EXTRA != 0) step();
        check("lu capture RegDstAddr_E", RegDstAddr_E, 9);
        check("lu total StallCount", StallCount, 1 + EXTRA);

        // Load to $0 is never tracked.
        setId(0, 0, 0, 0, 0, 1, 1);
        step();
        check("r0 RegWriteEN_E", RegWriteEN_E, 0);
        check("r0 MemRead_E", MemRead_E, 0);
        setId(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("r0 Stall_D", Stall_D, 0);
        step();

        // Matching Rt without UsesRt_D does not stall.
        setId(0, 0, 0, 0, 5, 1, 1);
        step();
        setId(3, 1, 5, 0, 0, 0, 0);
        #1;
        check("unused rt Stall_D", Stall_D, 0);
        step();

        // Taken branch together with a load-use: flush only.
        setId(0, 0, 0, 0, 7, 1, 1);
        step();
        setId(7, 1, 0, 0, 6, 1, 0);
        BranchTaken_E = 1'b1;
        #1;
        check("br Flush_D", Flush_D, 1);
        check("br Bubble_E", Bubble_E, 1);
        check("br Stall_D", Stall_D, 0);
        step();
        BranchTaken_E = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0);
        check("br RegWriteEN_E", RegWriteEN_E, 0);
        check("br RegDstAddr_M", RegDstAddr_M, 7);
        check("br StallCount", StallCount, 1 + EXTRA);

        // Memory wait with add $3 sitting in M.
        setId(0, 0, 0, 0, 3, 1, 0);
        step();
        setId(0, 0, 0, 0, 0, 0, 0);
        step();
        MemWait_M = 1'b1;
        #1;
        check("mw Freeze_M", Freeze_M, 1);
        check("mw Bubble_E", Bubble_E, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mw held RegDstAddr_M", RegDstAddr_M, 3);
        end
        check("mw StallCount", StallCount, 4 + EXTRA);
        MemWait_M = 1'b0;
        step();
        check("mw release RegDstAddr_W", RegDstAddr_W, 3);

        // Saturation of the narrow stall counter.
        MemWait_M = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("sat StallCount", StallCount, CNTMAX);

        // Asynchronous reset in the middle of a wait.
        #2;
        RST_N = 1'b0;
        #1;
        check("rst RegWriteEN_M", RegWriteEN_M, 0);
        check("rst RegDstAddr_W", RegDstAddr_W, 0);
        check("rst StallCount", StallCount, 0);
        check("rst Freeze_M", Freeze_M, 1);
        check("rst Stall_D", Stall_D, 0);
        BranchTaken_E = 1'b1;
        #1;
        check("rst Flush_D", Flush_D, 1);
        check("rst Bubble_E", Bubble_E, 0);
        BranchTaken_E = 1'b0;
        step();
        MemWait_M = 1'b0;
        RST_N = 1'b1;
        setId(0, 0, 0, 0, 4, 1, 0);
        step();
        check("post-rst RegDstAddr_E", RegDstAddr_E, 4);
        check("post-rst RegWriteEN_E", RegWriteEN_E, 1);

        // Load already in M when its reader reaches ID.
        setId(0, 0, 0, 0, 12, 1, 1);
        step();
        setId(0, 0, 0, 0, 0, 0, 0);
        step();
        setId(12, 1, 0, 0, 13, 1, 0);
        #1;
        check("luM Stall_D", Stall_D, EXTRA);
        step();
        step();
        setId(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
